// File: rtl/mov_fsm.sv
// MOV sequencer: IDLE/DECODE/XFER/PCINC/DONE loop; 5 cycles per MOV, 4 per non-MOV, Moore outputs.
// Free-running, with no backpressure: the instruction word is sampled on the IDLE->DECODE edge.
module mov_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fullBitNum,
  output logic        PC_inc,
  output logic        done,
  output logic        G0_in,
  output logic        G1_in,
  output logic        G2_in,
  output logic        G3_in,
  output logic        G0_out,
  output logic        G1_out,
  output logic        G2_out,
  output logic        G3_out,
  output logic        P0_in,
  output logic        P0_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    XFER   = 3'd2,
    PCINC  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] OP_MOV = 4'b0110;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] instr;
  logic [4:0]  src_sel;
  logic [4:0]  dst_sel;

  // One-hot register select {P0, G3, G2, G1, G0}; codes 5..F select nothing.
  function automatic logic [4:0] reg_decode(input logic [3:0] code);
    logic [4:0] sel;
    sel = 5'b0;
    if (code <= 4'h4) begin
      sel[code[2:0]] = 1'b1;
    end
    return sel;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      instr <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        instr <= fullBitNum;
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = DECODE;
      DECODE:  state_nxt = (instr[15:12] == OP_MOV) ? XFER : PCINC;
      XFER:    state_nxt = PCINC;
      PCINC:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign src_sel = reg_decode(instr[3:0]);
  assign dst_sel = reg_decode(instr[11:8]);

  always_comb begin
    PC_inc = 1'b0;
    done   = 1'b0;
    G0_in  = 1'b0;
    G1_in  = 1'b0;
    G2_in  = 1'b0;
    G3_in  = 1'b0;
    P0_in  = 1'b0;
    G0_out = 1'b0;
    G1_out = 1'b0;
    G2_out = 1'b0;
    G3_out = 1'b0;
    P0_out = 1'b0;
    case (state)
      XFER: begin
        {P0_in, G3_in, G2_in, G1_in, G0_in}      = dst_sel;
        {P0_out, G3_out, G2_out, G1_out, G0_out} = src_sel;
      end
      PCINC:   PC_inc = 1'b1;
      DONE:    done   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mov_fsm.sv
// Directed bench for mov_fsm: walks each pass cycle by cycle against hand-computed strobe words.
module tb_mov_fsm;

  logic        clk;
  logic        rst;
  logic [15:0] fullBitNum;
  logic        PC_inc, done;
  logic        G0_in, G1_in, G2_in, G3_in, P0_in;
  logic        G0_out, G1_out, G2_out, G3_out, P0_out;

  int n_vec  = 0;
  int n_miss = 0;

  // {PC_inc, done, G0_in, G1_in, G2_in, G3_in, P0_in, G0_out, G1_out, G2_out, G3_out, P0_out}
  localparam logic [11:0] V_ZERO  = 12'h000;
  localparam logic [11:0] V_PCINC = 12'h800;
  localparam logic [11:0] V_DONE  = 12'h400;

  mov_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .fullBitNum (fullBitNum),
    .PC_inc     (PC_inc),
    .done       (done),
    .G0_in      (G0_in),
    .G1_in      (G1_in),
    .G2_in      (G2_in),
    .G3_in      (G3_in),
    .G0_out     (G0_out),
    .G1_out     (G1_out),
    .G2_out     (G2_out),
    .G3_out     (G3_out),
    .P0_in      (P0_in),
    .P0_out     (P0_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [11:0] outs();
    return {PC_inc, done, G0_in, G1_in, G2_in, G3_in, P0_in,
            G0_out, G1_out, G2_out, G3_out, P0_out};
  endfunction

  task automatic chk_vec(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  // Starts with the DUT in IDLE; ins is presented for capture, ins_mid replaces it during DECODE.
  task automatic run_pass(input string tag, input logic [15:0] ins, input logic [15:0] ins_mid,
                          input logic [11:0] xfer_exp, input bit is_mov);
    fullBitNum = ins;
    chk_vec({tag, ".idle"}, outs(), V_ZERO);
    @(posedge clk); #1;
    fullBitNum = ins_mid;
    chk_vec({tag, ".decode"}, outs(), V_ZERO);
    if (is_mov) begin
      @(posedge clk); #1;
      chk_vec({tag, ".xfer"}, outs(), xfer_exp);
    end
    @(posedge clk); #1;
    chk_vec({tag, ".pcinc"}, outs(), V_PCINC);
    @(posedge clk); #1;
    chk_vec({tag, ".done"}, outs(), V_DONE);
    @(posedge clk); #1;
    chk_vec({tag, ".wrap"}, outs(), V_ZERO);
  endtask

  initial begin
    rst        = 1'b0;
    fullBitNum = 16'h6002;
    #1;
    chk_vec("rst.async", outs(), V_ZERO);
    repeat (3) begin
      @(posedge clk); #1;
      chk_vec("rst.held", outs(), V_ZERO);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;

    run_pass("mov_g0_g2.a", 16'h6002, 16'h6002, 12'h204, 1'b1);
    run_pass("mov_g0_g2.b", 16'h6002, 16'h6002, 12'h204, 1'b1);
    run_pass("mov_p0_g3",   16'h6403, 16'h6403, 12'h022, 1'b1);
    run_pass("nonmov.a",    16'h1002, 16'h1002, V_ZERO,  1'b0);
    run_pass("nonmov.b",    16'h1002, 16'h1002, V_ZERO,  1'b0);
    run_pass("capture.cur", 16'h6002, 16'h6130, 12'h204, 1'b1);
    run_pass("capture.nxt", 16'h6130, 16'h6130, 12'h110, 1'b1);
    run_pass("bad_dst",     16'h6F01, 16'h6F01, 12'h008, 1'b1);
    run_pass("self_g1",     16'h6101, 16'h6101, 12'h108, 1'b1);

    // Reset dropped in the middle of XFER must clear the strobes without a clock edge.
    fullBitNum = 16'h6002;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_vec("midrst.xfer", outs(), 12'h204);
    #4;
    rst = 1'b0;
    #1;
    chk_vec("midrst.async", outs(), V_ZERO);
    repeat (2) begin
      @(posedge clk); #1;
      chk_vec("midrst.held", outs(), V_ZERO);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    run_pass("after_rst", 16'h6403, 16'h6403, 12'h022, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
